// File: rtl/ingress_port_buffer_if.sv
// ingress_port_buffer_if: input byte stream, switch request/grant and output stream of one ingress port.
interface ingress_port_buffer_if #(
  parameter int DATA_W = 8,
  parameter int PORTS  = 4
);
  localparam int PW = $clog2(PORTS);
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic [DATA_W-1:0] in_data;
  logic              out_req;
  logic [PW-1:0]     out_dest;
  logic              out_gnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_eop;
  logic [15:0]       pkt_count;
  logic [15:0]       drop_count;
  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_gnt,
    output out_req, out_dest, out_valid, out_data, out_eop, pkt_count, drop_count
  );
  modport master (
    output in_valid, in_sop, in_eop, in_data, out_gnt,
    input  out_req, out_dest, out_valid, out_data, out_eop, pkt_count, drop_count
  );
endinterface

// File: rtl/ingress_port_buffer.sv
// ingress_port_buffer: store-and-forward packet buffer that only releases whole packets to the switch.
// Optional packet/drop statistics are built when INGRESS_STATS_EN is defined.
module ingress_port_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PORTS  = 4
) (
  input logic clk,
  input logic reset,
  ingress_port_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PORTS);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] PTR_FULL = DEPTH;
  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_DISCARD} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_XFER} r_state_e;
  logic [DATA_W:0] mem_q [DEPTH];
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d, ready_q, ready_d, base;
  logic out_req_q, out_req_d, out_valid_q, out_valid_d, out_eop_q, out_eop_d;
  logic [PW-1:0] out_dest_q, out_dest_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W:0] rd_word;
  logic take, ovf, wr_en, commit, fetch, done;
  // a header always restarts at the last commit point, which also aborts any open packet
  assign base = bus.in_sop ? commit_ptr_q : wr_ptr_q;
  assign take = bus.in_valid && (bus.in_sop || w_state_q == W_LOAD);
  assign ovf = take && (base - rd_ptr_q) == PTR_FULL;
  assign wr_en = take && !ovf;
  assign commit = wr_en && bus.in_eop;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign fetch = (r_state_q == R_REQ && bus.out_gnt) || (r_state_q == R_XFER && !out_eop_q);
  assign done = r_state_q == R_XFER && out_eop_q;
  always_comb begin
    w_state_d = w_state_q;
    wr_ptr_d = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    if (ovf) begin
      wr_ptr_d = commit_ptr_q;
      w_state_d = bus.in_eop ? W_IDLE : W_DISCARD;
    end else if (wr_en) begin
      wr_ptr_d = base + PTR_ONE;
      commit_ptr_d = bus.in_eop ? base + PTR_ONE : commit_ptr_q;
      w_state_d = bus.in_eop ? W_IDLE : W_LOAD;
    end else if (bus.in_valid && bus.in_eop && w_state_q == W_DISCARD) begin
      w_state_d = W_IDLE;
    end
  end
  always_comb begin
    r_state_d = r_state_q;
    out_req_d = out_req_q;
    out_dest_d = out_dest_q;
    out_valid_d = out_valid_q;
    out_eop_d = out_eop_q;
    out_data_d = out_data_q;
    rd_ptr_d = rd_ptr_q;
    if (r_state_q == R_IDLE && ready_q != '0) begin
      r_state_d = R_REQ;
      out_req_d = 1'b1;
      out_dest_d = rd_word[PW-1:0];
    end
    if (fetch) begin
      r_state_d = R_XFER;
      out_req_d = 1'b0;
      out_valid_d = 1'b1;
      {out_eop_d, out_data_d} = rd_word;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (done) begin
      r_state_d = R_IDLE;
      out_valid_d = 1'b0;
      out_eop_d = 1'b0;
    end
    ready_d = ready_q + (commit ? PTR_ONE : '0) - (done ? PTR_ONE : '0);
  end
  always_ff @(posedge clk) if (wr_en) mem_q[base[AW-1:0]] <= {bus.in_eop, bus.in_data};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q <= '0;
      out_req_q <= 1'b0;
      out_dest_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_eop_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q <= ready_d;
      out_req_q <= out_req_d;
      out_dest_q <= out_dest_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_eop_q <= out_eop_d;
    end
  end
  assign bus.out_req = out_req_q;
  assign bus.out_dest = out_dest_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_eop = out_eop_q;
`ifdef INGRESS_STATS_EN
  logic [15:0] pkt_q, drop_q;
  logic [16:0] drop_sum;
  logic abort;
  // an abort whose new header also overflows drops two packets in one cycle
  assign abort = bus.in_valid && bus.in_sop && w_state_q == W_LOAD;
  assign drop_sum = {1'b0, drop_q} + 17'(abort) + 17'(ovf);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      pkt_q <= (done && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
  assign bus.pkt_count = pkt_q;
  assign bus.drop_count = drop_q;
`else
  assign bus.pkt_count = '0;
  assign bus.drop_count = '0;
`endif
endmodule

// File: tb/tb_ingress_port_buffer.sv
// tb_ingress_port_buffer: packet table plus directed corner sequences, checked against a byte/destination scoreboard.
module tb_ingress_port_buffer;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  ingress_port_buffer_if bus ();
  ingress_port_buffer dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [7:0] hdr;
    int len;
    int gnt_delay;
    int fwd;
    int drops;
  } rec_t;
  rec_t tbl [6];

  int tests = 0, fails = 0;
  int cyc = 0, eop_cyc = 0, last_req_cyc = 0, gnt_cyc = 0, last_eop_cyc = -1000;
  int gnt_delay = 0, wait_cnt = 0;
  logic [8:0] exp_q [$];
  logic [1:0] dest_q [$];
  logic [1:0] cur_dest;
  bit req_seen = 0, prev_valid = 0, prev_eop = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      req_seen = 0;
      bus.out_gnt = 0;
    end else begin
      if (bus.out_req && !req_seen) begin
        req_seen = 1;
        wait_cnt = 0;
        last_req_cyc = cyc;
        cur_dest = bus.out_dest;
        if (dest_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got dest %0d expected no request", bus.out_dest);
        end else check("out_dest", 32'(bus.out_dest), 32'(dest_q.pop_front()));
        if (last_eop_cyc >= 0) check("req_after_eop", 32'(cyc >= last_eop_cyc + 2), 1);
      end else if (bus.out_req) check("dest_stable", 32'(bus.out_dest), 32'(cur_dest));
      if (!bus.out_req) req_seen = 0;
      bus.out_gnt = req_seen && wait_cnt >= gnt_delay;
      if (bus.out_gnt) gnt_cyc = cyc;
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 0;
      prev_eop = 0;
      last_eop_cyc = -1000;
    end else begin
      if (bus.out_valid) begin
        if (!prev_valid) check("first_byte_lat", 32'(cyc), 32'(gnt_cyc + 1));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %0h expected no byte", {bus.out_eop, bus.out_data});
        end else check("out_byte", 32'({bus.out_eop, bus.out_data}), 32'(exp_q.pop_front()));
        if (bus.out_eop) last_eop_cyc = cyc;
      end else if (prev_valid && !prev_eop) begin
        tests++;
        fails++;
        $display("FAIL byte_gap: got idle cycle expected next byte");
      end
      prev_valid = bus.out_valid;
      prev_eop = bus.out_eop;
    end
  end

  task automatic do_reset();
    reset = 0;
    bus.in_valid = 0;
    bus.in_sop = 0;
    bus.in_eop = 0;
    bus.in_data = 0;
    exp_q.delete();
    dest_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic send(input logic [7:0] hdr, input int len, input bit eop, input bit fwd);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1;
      bus.in_sop = (i == 0);
      bus.in_eop = eop && (i == len - 1);
      bus.in_data = (i == 0) ? hdr : 8'(8'hA0 + i);
      if (fwd) exp_q.push_back({bus.in_eop, bus.in_data});
      if (bus.in_eop) eop_cyc = cyc;
    end
    if (fwd) dest_q.push_back(hdr[1:0]);
  endtask

  task automatic idle_drain(input string name);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_sop = 0;
    bus.in_eop = 0;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || dest_q.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size() + dest_q.size()), 0);
  endtask

  task automatic check_counts(input int pkts, input int drops);
`ifdef INGRESS_STATS_EN
    check("pkt_count", 32'(bus.pkt_count), 32'(pkts));
    check("drop_count", 32'(bus.drop_count), 32'(drops));
`else
    check("pkt_count", 32'(bus.pkt_count), 0 * pkts);
    check("drop_count", 32'(bus.drop_count), 0 * drops);
`endif
  endtask

  initial begin
    int k;
    tbl[0] = '{8'h02, 4, 0, 1, 0};
    tbl[1] = '{8'h03, 1, 0, 1, 0};
    tbl[2] = '{8'h01, 20, 0, 0, 1};
    tbl[3] = '{8'h5E, 16, 2, 1, 0};
    tbl[4] = '{8'h41, 17, 0, 0, 1};
    tbl[5] = '{8'hFF, 7, 3, 1, 0};
    bus.in_valid = 0;
    bus.in_sop = 0;
    bus.in_eop = 0;
    bus.in_data = 0;
    #2 reset = 0;
    #1;
    check("rst_out_req", 32'(bus.out_req), 0);
    check("rst_out_dest", 32'(bus.out_dest), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_eop", 32'(bus.out_eop), 0);
    check_counts(0, 0);

    foreach (tbl[i]) begin
      do_reset();
      gnt_delay = tbl[i].gnt_delay;
      send(tbl[i].hdr, tbl[i].len, 1, tbl[i].fwd != 0);
      idle_drain("table_drain");
      if (tbl[i].fwd != 0) check("req_latency", 32'(last_req_cyc - eop_cyc), 2);
      check_counts(tbl[i].fwd, tbl[i].drops);
    end

    do_reset();
    gnt_delay = 0;
    send(8'h01, 2, 0, 0);
    send(8'h02, 4, 1, 1);
    idle_drain("abort_drain");
    check_counts(1, 1);

    do_reset();
    send(8'h01, 20, 1, 0);
    send(8'h23, 3, 1, 1);
    idle_drain("long_then_short_drain");
    check_counts(1, 1);

    do_reset();
    gnt_delay = 10;
    send(8'h11, 5, 1, 1);
    send(8'h16, 5, 1, 1);
    idle_drain("back_to_back_drain");
    check_counts(2, 0);

    do_reset();
    gnt_delay = 0;
    send(8'h01, 5, 1, 1);
    @(posedge clk);
    #1 bus.in_valid = 0;
    bus.in_eop = 0;
    bus.in_sop = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_data == 8'hA1) break;
    end
    check("reach_byte2", 32'(k < 50), 1);
    #1 reset = 0;
    #1;
    check("xrst_out_req", 32'(bus.out_req), 0);
    check("xrst_out_valid", 32'(bus.out_valid), 0);
    check("xrst_out_data", 32'(bus.out_data), 0);
    check("xrst_out_eop", 32'(bus.out_eop), 0);
    check("xrst_out_dest", 32'(bus.out_dest), 0);
    exp_q.delete();
    dest_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    repeat (10) @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 0);
    check("post_rst_req", 32'(bus.out_req), 0);
    check_counts(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
